// File: rtl/ka_82bit_seq.sv
// ka_82bit_seq -- iterative 82x82 carry-less Karatsuba multiplier.
// One combinational 41-bit Karatsuba core is reused for the low, high
// and middle sub-products on three successive cycles, then the 163-bit
// product is recombined and held on y until the consumer accepts it.
// Optional feature macro: KA82_SEQ_PERF_CNT_EN (completed-operation counter).

// ka_41bit -- combinational 41x41 carry-less product (81 bits), one
// Karatsuba level over a 21/20-bit split.
module ka_41bit (
   input  logic [40:0] i_a,
   input  logic [40:0] i_b,
   output logic [80:0] o_p
);

   // Schoolbook carry-less product of two 21-bit polynomials.
   function automatic logic [40:0] f_clmul21(input logic [20:0] x, input logic [20:0] z);
      logic [40:0] acc;
      acc = '0;
      for (int i = 0; i < 21; i++) begin
         if (z[i]) acc = acc ^ ({20'b0, x} << i);
      end
      return acc;
   endfunction

   logic [20:0] w_a_hi;
   logic [20:0] w_b_hi;
   logic [40:0] w_lo;
   logic [40:0] w_hi;
   logic [40:0] w_mm;
   logic [40:0] w_mid;

   assign w_a_hi = {1'b0, i_a[40:21]};
   assign w_b_hi = {1'b0, i_b[40:21]};
   assign w_lo   = f_clmul21(i_a[20:0], i_b[20:0]);
   assign w_hi   = f_clmul21(w_a_hi, w_b_hi);
   assign w_mm   = f_clmul21(i_a[20:0] ^ w_a_hi, i_b[20:0] ^ w_b_hi);
   assign w_mid  = w_mm ^ w_lo ^ w_hi;
   assign o_p    = ({40'b0, w_hi} << 42) ^ ({40'b0, w_mid} << 21) ^ {40'b0, w_lo};

endmodule

module ka_82bit_seq (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [81:0]  a,
   input  logic [81:0]  b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [162:0] y,
   output logic         busy,
   output logic [31:0]  op_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MUL_LO  = 3'd1,
      S_MUL_HI  = 3'd2,
      S_MUL_MID = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [81:0]    r_a;
   logic [81:0]    r_b;
   logic [80:0]    r_p_lo;
   logic [80:0]    r_p_hi;
   logic [162:0]   r_y;
   logic [40:0]    w_op_a;
   logic [40:0]    w_op_b;
   logic [80:0]    w_prod;
   logic [80:0]    w_mid;
   logic [162:0]   w_y_next;
   logic           w_in_ready;
   logic           w_out_valid;

   ka_41bit u_ka41 (
      .i_a (w_op_a),
      .i_b (w_op_b),
      .o_p (w_prod)
   );

   // Middle term removes the low/high contributions; overlap recombination.
   assign w_mid    = w_prod ^ r_p_lo ^ r_p_hi;
   assign w_y_next = {r_p_hi, 82'b0} ^ ({82'b0, w_mid} << 41) ^ {82'b0, r_p_lo};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state, handshake outputs and shared-core operand mux.
   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_op_a      = '0;
      w_op_b      = '0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) w_next = S_MUL_LO;
         end
         S_MUL_LO: begin
            w_op_a = r_a[40:0];
            w_op_b = r_b[40:0];
            w_next = S_MUL_HI;
         end
         S_MUL_HI: begin
            w_op_a = r_a[81:41];
            w_op_b = r_b[81:41];
            w_next = S_MUL_MID;
         end
         S_MUL_MID: begin
            w_op_a = r_a[40:0] ^ r_a[81:41];
            w_op_b = r_b[40:0] ^ r_b[81:41];
            w_next = S_DONE;
         end
         S_DONE: begin
            w_out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      // Abort overrides every handshake, including a capture in IDLE.
      if (clear) w_next = S_IDLE;
   end

   // Operand capture, sub-product registers and result register; an abort
   // freezes them so a partial product never reaches y.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_p_lo <= '0;
         r_p_hi <= '0;
         r_y    <= '0;
      end else if (!clear) begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a    <= a;
                  r_b    <= b;
                  r_p_lo <= '0;
                  r_p_hi <= '0;
               end
            end
            S_MUL_LO:  r_p_lo <= w_prod;
            S_MUL_HI:  r_p_hi <= w_prod;
            S_MUL_MID: r_y    <= w_y_next;
            default: ;
         endcase
      end
   end

`ifdef KA82_SEQ_PERF_CNT_EN
   logic        r_op_count;
   logic [31:0] r_op_cnt;
   logic        w_hs;

   assign w_hs = (r_state == S_DONE) && out_ready && !clear;

   // Completed-operation counter; wraps naturally, cleared only by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_op_cnt <= '0;
      else if (w_hs) r_op_cnt <= r_op_cnt + 32'd1;
   end

   // Registered handshake marker kept for observation alongside the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_op_count <= 1'b0;
      else        r_op_count <= w_hs;
   end

   assign op_count = r_op_cnt;
`else
   assign op_count = 32'h0;
`endif

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign busy      = (r_state != S_IDLE);
   assign y         = r_y;

endmodule

// File: tb/tb_ka_82bit_seq.sv
// tb_ka_82bit_seq -- randomized self-checking bench for ka_82bit_seq.
// Builds with or without KA82_SEQ_PERF_CNT_EN; the expected op_count
// follows the same macro.
module tb_ka_82bit_seq;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clear = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [81:0]  a = '0;
   logic [81:0]  b = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [162:0] y;
   logic [31:0]  op_count;

   int           n_err = 0;
   int           n_chk = 0;
   logic [31:0]  exp_cnt = '0;

   ka_82bit_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // Reference: bit-serial shift-and-XOR polynomial product.
   function automatic logic [162:0] clmul(input logic [81:0] x, input logic [81:0] z);
      logic [162:0] r;
      r = '0;
      for (int i = 0; i < 82; i++)
         if (z[i]) r = r ^ ({81'b0, x} << i);
      return r;
   endfunction

   function automatic logic [81:0] rnd82();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[81:0];
   endfunction

   task automatic check(input string tag, input logic [162:0] got, input logic [162:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Counts edges after the accept edge until out_valid is seen (bounded).
   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!out_valid && n < 20);
   endtask

   // Called at a negedge with the block idle; returns just after the accept edge.
   task automatic accept(input logic [81:0] ia, input logic [81:0] ib);
      check("in_ready_idle", in_ready, 1'b1);
      in_valid = 1'b1;
      a = ia;
      b = ib;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Full operation with out_ready high; ends at a negedge, block idle.
   task automatic run_op(input logic [81:0] ia, input logic [81:0] ib);
      int n;
      out_ready = 1'b1;
      accept(ia, ib);
      wait_valid(n);
      check("latency", n, 3);
      check("y_model", y, clmul(ia, ib));
      check("in_ready_done", in_ready, 1'b0);
      @(posedge clk);
`ifdef KA82_SEQ_PERF_CNT_EN
      exp_cnt = exp_cnt + 32'd1;
`endif
      @(negedge clk);
      check("out_valid_after_hs", out_valid, 1'b0);
      check("in_ready_after_hs", in_ready, 1'b1);
      check("op_count", op_count, exp_cnt);
   endtask

   initial begin
      logic [162:0] y_hold;
      logic [81:0]  ra, rb;
      int           n;

      // Reset state while rst_n is low.
      #12;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_y", y, '0);
      check("rst_op_count", op_count, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed corner products.
      run_op(82'h1, 82'h1);
      check("y_1x1", y, 163'h1);
      run_op(82'h3, 82'h3);
      check("y_3x3", y, 163'h5);
      run_op({82{1'b1}}, 82'h1);
      check("y_ones", y, {81'b0, {82{1'b1}}});
      run_op(82'h1 << 81, 82'h1 << 81);
      check("y_top", y, 163'h1 << 162);

      // Randomized operands: dense, sparse and saturated patterns.
      for (int k = 0; k < 1000; k++) begin
         case ($urandom_range(0, 3))
            0: begin ra = rnd82() & rnd82(); rb = rnd82(); end
            1: begin ra = 82'h1 << $urandom_range(0, 81); rb = rnd82(); end
            2: begin ra = {82{1'b1}}; rb = rnd82(); end
            default: begin ra = rnd82(); rb = rnd82(); end
         endcase
         run_op(ra, rb);
      end

      // Back-pressure: result held, new operands ignored.
      ra = rnd82();
      rb = rnd82();
      out_ready = 1'b0;
      accept(ra, rb);
      wait_valid(n);
      check("bp_latency", n, 3);
      check("bp_y", y, clmul(ra, rb));
      y_hold = y;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         a = rnd82();
         b = rnd82();
         @(posedge clk);
         @(negedge clk);
         check("bp_out_valid", out_valid, 1'b1);
         check("bp_y_stable", y, y_hold);
         check("bp_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
`ifdef KA82_SEQ_PERF_CNT_EN
      exp_cnt = exp_cnt + 32'd1;
`endif
      @(negedge clk);
      check("bp_release_valid", out_valid, 1'b0);
      check("bp_release_ready", in_ready, 1'b1);
      check("bp_release_busy", busy, 1'b0);
      check("bp_op_count", op_count, exp_cnt);
      run_op(rnd82(), rnd82());

      // Abort in MUL_HI.
      y_hold = y;
      accept(rnd82(), rnd82());
      @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      @(negedge clk);
      check("clr_busy", busy, 1'b0);
      check("clr_in_ready", in_ready, 1'b1);
      for (int k = 0; k < 5; k++) begin
         check("clr_out_valid", out_valid, 1'b0);
         @(negedge clk);
      end
      check("clr_y_hold", y, y_hold);
      check("clr_op_count", op_count, exp_cnt);
      run_op(rnd82(), rnd82());

      // clear and in_valid together in IDLE: no capture.
      clear = 1'b1;
      in_valid = 1'b1;
      a = rnd82();
      b = rnd82();
      @(posedge clk);
      #1 clear = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("clr_idle_busy", busy, 1'b0);
      repeat (4) @(negedge clk);
      check("clr_idle_out_valid", out_valid, 1'b0);
      run_op(82'h5, 82'h7);
      check("y_5x7", y, 163'h1b);

`ifdef KA82_SEQ_PERF_CNT_EN
      // Counter wrap from all-ones.
      force dut.r_op_cnt = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.r_op_cnt;
      exp_cnt = 32'hFFFF_FFFF;
      check("cnt_preload", op_count, exp_cnt);
      run_op(rnd82(), rnd82());
      check("cnt_wrap", op_count, 32'h0);
`endif

      // Asynchronous reset during MUL_MID.
      accept(rnd82() | 82'h1, 82'h1);
      @(posedge clk);
      @(posedge clk);
      #2;
      check("mid_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", in_ready, 1'b1);
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_y", y, '0);
      check("arst_op_count", op_count, 32'h0);
      exp_cnt = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(rnd82(), rnd82());

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ka_82bit_seq.md
# ka_82bit_seq

Iterative sequencer for an area-reduced 82×82-bit GF(2)[x] (carry-less) Karatsuba multiplication. It time-shares a single combinational KA_41bit instance across the three Karatsuba sub-products (low, high, middle) on successive cycles, then applies the 82-bit overlap/recombination. The 163-bit product is returned over a valid/ready handshake. It is the low-area alternative to the fully parallel 82-bit multiplier, used by the 163-bit field-multiply path when three 41-bit multipliers are too costly.

## Interface
- No parameters; widths are fixed at 82-bit operands and 163-bit result.
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort; returns the FSM to IDLE, takes priority over every handshake
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  82  operand A (polynomial coefficients, bit i = x^i)
- b  in  82  operand B
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- y  out  163  carry-less product a·b
- busy  out  1  high in any state other than IDLE
- op_count  out  32  completed-operation counter (see Configuration)

## Operation
- FSM states: IDLE, MUL_LO, MUL_HI, MUL_MID, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, capture a and b into internal registers (a_r, b_r), clear the accumulator, and go to MUL_LO.
- The shared KA_41bit operand mux depends on state:
  - MUL_LO: a_r[40:0], b_r[40:0].
  - MUL_HI: a_r[81:41], b_r[81:41].
  - MUL_MID: a_r[40:0]^a_r[81:41], b_r[40:0]^b_r[81:41].
  - Other states: drive zero.
- MUL_LO: register the 81-bit product into p_lo. Next state MUL_HI.
- MUL_HI: register the product into p_hi. Next state MUL_MID.
- MUL_MID: form mid = prod ^ p_lo ^ p_hi and register y = {p_hi,82'b0} ^ (mid<<41) ^ p_lo, all zero-extended to 163 bits. Next state DONE.
- DONE: out_valid=1; y is stable until the handshake completes. On out_ready, go to IDLE.
- in_ready is 0 outside IDLE. in_valid presented in those states is ignored and is not queued.
- All arithmetic is XOR only; there are no carries and no modular reduction.
- clear in any state: go to IDLE; out_valid falls; y holds its last value; op_count is unchanged.
- If clear and in_valid are both high in IDLE, clear wins and no capture occurs.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, y=0, op_count=0, and internal registers 0.
- Accept edge E0. out_valid rises after edge E3, giving a latency of 3 cycles from accept to result.
- The output handshake occurs at the first edge with out_valid & out_ready. in_ready rises after that edge.
- Minimum initiation interval is 5 cycles. There is no back-to-back overlap.
- Under back-pressure (out_ready=0), out_valid stays 1 and y stays constant indefinitely.
- Reset asserted mid-operation aborts immediately to the reset values. A partially computed product never appears on y.
- The critical path is the operand mux → KA_41bit → XOR recombination → y register, all within one cycle.

## Configuration
- KA82_SEQ_PERF_CNT_EN defined: op_count increments by 1 on every output handshake. It wraps from 0xFFFFFFFF to 0 and is cleared only by rst_n.
- KA82_SEQ_PERF_CNT_EN undefined: the counter logic is not synthesised and op_count is tied to 32'h0. All other behaviour is identical.

## Test plan
- a=82'h1, b=82'h1, out_ready=1 → out_valid exactly 3 cycles after accept; y=163'h1; in_ready back one cycle later.
- a=82'h3, b=82'h3 → y=163'h5 (carry-less). a=all-ones (82 bits), b=82'h1 → y equals a zero-extended.
- a=b=2^81 → y has only bit 162 set. Then 1000 random pairs are checked against a bit-serial carry-less reference model.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid → y constant, in_ready=0, new in_valid ignored. Release → one handshake, then the next operand pair is accepted.
- Abort cases:
  - clear asserted in MUL_HI → IDLE next cycle; out_valid never rises; the next operation produces a correct result.
  - rst_n pulsed low in MUL_MID → all outputs return to reset values asynchronously.
- With KA82_SEQ_PERF_CNT_EN: 5 completed ops → op_count=5, and a cleared op does not count. Preload the counter to 0xFFFFFFFF via force → one op → 0. Without the macro: op_count=0 throughout.
